adc_trans_top: RTL and testbench

- Top-level ADC sample-transfer block with a built-in sample source, so it needs no ADC input pins.
- Captures a block of 16-bit samples into an internal synchronous FIFO at a fixed sample rate.
- Drains the block at a slower, UART-style pacing rate onto data_tx_o, then repeats.
- Feeds the downstream UART transmitter stage.

---
 rtl/adc_trans_top.sv | 157 +++++++++++++++
 tb/tb_adc_trans_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trans_top.sv
// Single-clock FIFO for sample words; registered read port that holds its last word.
// Latency: read data and its valid pulse appear one edge after the read is accepted.
// Backpressure: none; writes while full and reads while empty are dropped.
module adc_trans_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_vld,
    output logic [DW-1:0] rd_dat,
    output logic          rd_dat_vld,
    output logic [AW:0]   count,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_wr, do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_vld && !full;
    assign do_rd = rd_vld && !empty;

    // storage is left unreset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_dat     <= '0;
            rd_dat_vld <= 1'b0;
        end else begin
            rd_dat_vld <= do_rd;
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_dat <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// ADC sample transfer: captures a FIFO-full block of counter samples, then drains it at UART pace.
// Latency: one word per TX_DIV cycles; each word lands one edge after its read is issued.
// Backpressure: none; capture and transmit alternate so the FIFO never overflows.
module adc_trans_top #(
    parameter int              DATA_W      = 16,
    parameter int              FIFO_AW     = 4,
    parameter int              SAMPLE_DIV  = 4,
    parameter int              TX_DIV      = 8,
    parameter logic [DATA_W-1:0] SAMPLE_INIT = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic [DATA_W-1:0] data_tx_o,
    output logic              tx_valid_o,
    output logic              busy_tx_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TX_W  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(TX_DIV - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, TRANSMIT} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [TX_W-1:0]   tx_cnt;
    logic [DATA_W-1:0] sample_val;
    logic              wr_en, rd_en, fifo_empty;
    logic [FIFO_AW:0]  fifo_count;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: state_d = CAPTURE;
            CAPTURE: begin
                if (div_cnt == DIV_LAST) begin
                    wr_en = 1'b1;
                    if (fifo_count == (FIFO_AW+1)'(DEPTH - 1))
                        state_d = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (tx_cnt == TX_LAST && !fifo_empty) begin
                    rd_en = 1'b1;
                    if (fifo_count == (FIFO_AW+1)'(1))
                        state_d = CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // pacing counters restart whenever their phase is entered
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt    <= '0;
            tx_cnt     <= '0;
            sample_val <= SAMPLE_INIT;
        end else begin
            if (state_q == CAPTURE && state_d == CAPTURE)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
            if (state_q == TRANSMIT && state_d == TRANSMIT)
                tx_cnt <= (tx_cnt == TX_LAST) ? '0 : tx_cnt + 1'b1;
            else
                tx_cnt <= '0;
            if (wr_en)
                sample_val <= sample_val + 1'b1;
        end
    end

    adc_trans_fifo #(
        .DW (DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .wr_vld     (wr_en),
        .wr_dat     (sample_val),
        .rd_vld     (rd_en),
        .rd_dat     (data_tx_o),
        .rd_dat_vld (tx_valid_o),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    assign busy_tx_o = (state_q == TRANSMIT);
endmodule

// File: tb/tb_adc_trans_top.sv
// Directed bench for adc_trans_top: reset, block ordering, pacing, hold, wrap and mid-block reset.
module tb_adc_trans_top;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] data_tx_o, data1;
    logic        tx_valid_o, vld1, busy_tx_o, busy1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cyc = 0;

    logic [15:0] p_dat[$];
    int          p_cyc[$];
    logic        p_busy[$];
    logic [15:0] q1_dat[$];
    int          low_runs[$];
    int          low_run  = 0;
    int          hold_err = 0;
    int          dbl_vld  = 0;
    logic [15:0] prev_dat = '0;
    logic        prev_vld = 1'b0;

    adc_trans_top dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_tx_o  (data_tx_o),
        .tx_valid_o (tx_valid_o),
        .busy_tx_o  (busy_tx_o)
    );

    adc_trans_top #(.SAMPLE_INIT(16'hFFF8)) dut_wrap (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data_tx_o  (data1),
        .tx_valid_o (vld1),
        .busy_tx_o  (busy1)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            low_run  <= 0;
            prev_dat <= data_tx_o;
            prev_vld <= 1'b0;
        end else begin
            if (tx_valid_o) begin
                p_dat.push_back(data_tx_o);
                p_cyc.push_back(cyc);
                p_busy.push_back(busy_tx_o);
                if (prev_vld) dbl_vld <= dbl_vld + 1;
            end else if (data_tx_o !== prev_dat) begin
                hold_err <= hold_err + 1;
            end
            prev_dat <= data_tx_o;
            prev_vld <= tx_valid_o;
            if (busy_tx_o) begin
                if (low_run > 0) low_runs.push_back(low_run);
                low_run <= 0;
            end else begin
                low_run <= low_run + 1;
            end
            if (vld1) q1_dat.push_back(data1);
        end
    end

    task automatic wait_pulses(input int n, output bit ok);
        int k = 0;
        while (p_dat.size() < n && k < 600) begin
            @(negedge sys_clk);
            k++;
        end
        ok = (p_dat.size() >= n);
    endtask

    task automatic test_reset;
        int n;
        int start;
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (data_tx_o !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h want=0000", data_tx_o); end
        checks++;
        if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", tx_valid_o); end
        checks++;
        if (busy_tx_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy_tx_o); end
        repeat (3) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        start = cyc;
        n = 0;
        while (busy_tx_o !== 1'b1 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        rise_cyc = cyc;
        checks++;
        if (busy_tx_o !== 1'b1) begin failures++; $display("FAIL busy_timeout got=%b want=1", busy_tx_o); end
        checks++;
        if (cyc - start != 65) begin failures++; $display("FAIL idle_capture_edges got=%0d want=65", cyc - start); end
        checks++;
        if (p_dat.size() != 0) begin failures++; $display("FAIL early_output got=%0d want=0", p_dat.size()); end
    endtask

    task automatic test_first_block;
        bit ok;
        wait_pulses(16, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL blk1_timeout got=%0d want=16", p_dat.size()); end
        else begin
            checks++;
            if (p_cyc[0] - rise_cyc != 8) begin failures++; $display("FAIL first_latency got=%0d want=8", p_cyc[0] - rise_cyc); end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (p_dat[i] !== 16'(i)) begin failures++; $display("FAIL blk1_data[%0d] got=%h want=%h", i, p_dat[i], 16'(i)); end
                checks++;
                if (p_busy[i] !== (i < 15)) begin failures++; $display("FAIL blk1_busy[%0d] got=%b want=%b", i, p_busy[i], i < 15); end
                if (i > 0) begin
                    checks++;
                    if (p_cyc[i] - p_cyc[i-1] != 8) begin failures++; $display("FAIL blk1_gap[%0d] got=%0d want=8", i, p_cyc[i] - p_cyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_second_block;
        bit ok;
        int n = 0;
        logic [15:0] last = '0;
        while (busy_tx_o !== 1'b1 && n < 300) begin
            last = data_tx_o;
            @(negedge sys_clk);
            n++;
        end
        @(negedge sys_clk);
        checks++;
        if (last !== 16'h000F) begin failures++; $display("FAIL capture_hold got=%h want=000f", last); end
        checks++;
        if (low_runs.size() < 2 || low_runs[1] != 64) begin
            failures++;
            $display("FAIL busy_low_gap got=%0d want=64", (low_runs.size() < 2) ? -1 : low_runs[1]);
        end
        wait_pulses(32, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL blk2_timeout got=%0d want=32", p_dat.size()); end
        else begin
            checks++;
            if (p_cyc[16] - p_cyc[15] != 72) begin failures++; $display("FAIL burst_gap got=%0d want=72", p_cyc[16] - p_cyc[15]); end
            for (int i = 16; i < 32; i++) begin
                checks++;
                if (p_dat[i] !== 16'(i)) begin failures++; $display("FAIL blk2_data[%0d] got=%h want=%h", i, p_dat[i], 16'(i)); end
            end
        end
    endtask

    task automatic test_hold;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (hold_err != 0) begin failures++; $display("FAIL hold_changes got=%0d want=0", hold_err); end
        checks++;
        if (dbl_vld != 0) begin failures++; $display("FAIL valid_width got=%0d want=0", dbl_vld); end
        checks++;
        if (data_tx_o !== 16'h001F) begin failures++; $display("FAIL hold_last got=%h want=001f", data_tx_o); end
        checks++;
        if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b want=0", tx_valid_o); end
    endtask

    task automatic test_wrap;
        logic [15:0] e;
        checks++;
        if (q1_dat.size() < 16) begin failures++; $display("FAIL wrap_count got=%0d want=16", q1_dat.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                e = 16'(16'hFFF8 + i);
                checks++;
                if (q1_dat[i] !== e) begin failures++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, q1_dat[i], e); end
            end
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        wait_pulses(37, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL blk3_timeout got=%0d want=37", p_dat.size()); end
        checks++;
        if (busy_tx_o !== 1'b1) begin failures++; $display("FAIL blk3_busy got=%b want=1", busy_tx_o); end
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (busy_tx_o !== 1'b0 || data_tx_o !== 16'h0000 || tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_outputs got=%b/%h/%b want=0/0000/0", busy_tx_o, data_tx_o, tx_valid_o);
        end
        p_dat.delete();
        p_cyc.delete();
        p_busy.delete();
        repeat (2) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        wait_pulses(16, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL post_rst_timeout got=%0d want=16", p_dat.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (p_dat[i] !== 16'(i)) begin failures++; $display("FAIL post_rst_data[%0d] got=%h want=%h", i, p_dat[i], 16'(i)); end
            end
            checks++;
            if (p_busy[14] !== 1'b1 || p_busy[15] !== 1'b0) begin
                failures++;
                $display("FAIL post_rst_len got=%b%b want=10", p_busy[14], p_busy[15]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_block();
        test_second_block();
        test_hold();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
